// File: rtl/flow_stats_updater.sv
// -----------------------------------------------------------------------------
// flow_stats_updater
//
// Read-modify-write front end for flow_storage. Each accepted packet
// descriptor issues a storage read; the returned record is updated (packet
// count + 1, byte count + size) and written back using the storage edit id.
// The same updated record is streamed to downstream feature logic.
//
// Optional feature macro: FLOW_STATS_SATURATE_EN
//   defined   -> count and bytes saturate at their all-ones value
//   undefined -> count and bytes wrap modulo 2^width
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   pkt_valid/pkt_ready             descriptor handshake
//   pkt_flow_id, pkt_size           descriptor fields
//   read_ready/read_en/read_id      storage read request
//   read_data_new/_found/read_data  storage read result
//   read_edit_id                    edit id returned with the result
//   write_ready/write_en            storage write-back handshake
//   write_edit_id, write_data       write-back record {count, bytes}
//   stats_valid/_flow_id/_count/_bytes  updated-record stream, no backpressure
//   error                           sticky: result arrived with nothing pending
// -----------------------------------------------------------------------------
module flow_stats_updater #(
   parameter int FLOW_ID_WIDTH = 16,
   parameter int EDIT_ID_WIDTH = 4,
   parameter int SIZE_WIDTH    = 11,
   parameter int COUNT_WIDTH   = 8,
   parameter int BYTES_WIDTH   = 24,
   parameter int PENDING_DEPTH = 8,
   localparam int DATA_WIDTH   = COUNT_WIDTH + BYTES_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pkt_valid,
   output logic                     pkt_ready,
   input  logic [FLOW_ID_WIDTH-1:0] pkt_flow_id,
   input  logic [SIZE_WIDTH-1:0]    pkt_size,
   input  logic                     read_ready,
   output logic                     read_en,
   output logic [FLOW_ID_WIDTH-1:0] read_id,
   input  logic                     read_data_new,
   input  logic                     read_data_found,
   input  logic [DATA_WIDTH-1:0]    read_data,
   input  logic [EDIT_ID_WIDTH-1:0] read_edit_id,
   input  logic                     write_ready,
   output logic                     write_en,
   output logic [EDIT_ID_WIDTH-1:0] write_edit_id,
   output logic [DATA_WIDTH-1:0]    write_data,
   output logic                     stats_valid,
   output logic [FLOW_ID_WIDTH-1:0] stats_flow_id,
   output logic [COUNT_WIDTH-1:0]   stats_count,
   output logic [BYTES_WIDTH-1:0]   stats_bytes,
   output logic                     error
);

   localparam int PTR_W  = $clog2(PENDING_DEPTH);
   localparam int OCC_W  = PTR_W + 1;
   localparam int PEND_W = FLOW_ID_WIDTH + SIZE_WIDTH;
   localparam int WQ_W   = EDIT_ID_WIDTH + FLOW_ID_WIDTH + DATA_WIDTH;

   localparam logic [PTR_W-1:0]   PTR_ONE      = PTR_W'(1);
   localparam logic [OCC_W-1:0]   OCC_ONE      = OCC_W'(1);
   localparam logic [OCC_W-1:0]   OCC_ZERO     = OCC_W'(0);
   localparam logic [OCC_W+1:0]   CREDIT_LIMIT = (OCC_W + 2)'(PENDING_DEPTH);

   // Updated packet count: a new flow starts at one.
   function automatic logic [COUNT_WIDTH-1:0] next_count(
      input logic                   found,
      input logic [COUNT_WIDTH-1:0] old_count
   );
      logic [COUNT_WIDTH:0] sum;
      if (found) begin
         sum = {1'b0, old_count} + {{COUNT_WIDTH{1'b0}}, 1'b1};
      end else begin
         sum = {{COUNT_WIDTH{1'b0}}, 1'b1};
      end
`ifdef FLOW_STATS_SATURATE_EN
      if (sum[COUNT_WIDTH]) begin
         next_count = {COUNT_WIDTH{1'b1}};
      end else begin
         next_count = sum[COUNT_WIDTH-1:0];
      end
`else
      next_count = sum[COUNT_WIDTH-1:0];
`endif
   endfunction

   // Updated byte count: a new flow starts at the packet size.
   function automatic logic [BYTES_WIDTH-1:0] next_bytes(
      input logic                   found,
      input logic [BYTES_WIDTH-1:0] old_bytes,
      input logic [SIZE_WIDTH-1:0]  pkt_bytes
   );
      logic [BYTES_WIDTH:0] ext;
      logic [BYTES_WIDTH:0] sum;
      ext = {{(BYTES_WIDTH + 1 - SIZE_WIDTH){1'b0}}, pkt_bytes};
      if (found) begin
         sum = {1'b0, old_bytes} + ext;
      end else begin
         sum = ext;
      end
`ifdef FLOW_STATS_SATURATE_EN
      if (sum[BYTES_WIDTH]) begin
         next_bytes = {BYTES_WIDTH{1'b1}};
      end else begin
         next_bytes = sum[BYTES_WIDTH-1:0];
      end
`else
      next_bytes = sum[BYTES_WIDTH-1:0];
`endif
   endfunction

   // Pending FIFO state: {flow_id, size} per issued read
   logic [PEND_W-1:0]        pend_mem_r [PENDING_DEPTH];
   logic [PTR_W-1:0]         pend_wr_ptr_r;
   logic [PTR_W-1:0]         pend_rd_ptr_r;
   logic [OCC_W-1:0]         pend_occ_r;

   // Write queue state: {edit_id, flow_id, count, bytes}
   logic [WQ_W-1:0]          wq_mem_r [PENDING_DEPTH];
   logic [PTR_W-1:0]         wq_wr_ptr_r;
   logic [PTR_W-1:0]         wq_rd_ptr_r;
   logic [OCC_W-1:0]         wq_occ_r;

   // Compute register between the read result and the write queue
   logic                     res_valid_r;
   logic [EDIT_ID_WIDTH-1:0] res_edit_r;
   logic [FLOW_ID_WIDTH-1:0] res_flow_r;
   logic [COUNT_WIDTH-1:0]   res_count_r;
   logic [BYTES_WIDTH-1:0]   res_bytes_r;

   logic                     error_r;

   logic [OCC_W+1:0]         credit_used_s;
   logic                     pkt_ready_s;
   logic                     pend_push_s;
   logic                     pend_pop_s;
   logic                     spurious_s;
   logic                     wq_pop_s;
   logic [PEND_W-1:0]        pend_head_s;
   logic [WQ_W-1:0]          wq_head_s;

   // Handshake, credit accounting and FIFO push/pop decisions
   always_comb begin
      credit_used_s = {2'b00, pend_occ_r} + {2'b00, wq_occ_r}
                    + {{(OCC_W + 1){1'b0}}, res_valid_r};
      if (reset) begin
         pkt_ready_s = 1'b0;
      end else begin
         pkt_ready_s = read_ready && (credit_used_s < CREDIT_LIMIT);
      end
      pend_push_s = pkt_valid && pkt_ready_s;
      if (pend_occ_r == OCC_ZERO) begin
         pend_pop_s = 1'b0;
         spurious_s = read_data_new;
      end else begin
         pend_pop_s = read_data_new;
         spurious_s = 1'b0;
      end
      wq_pop_s    = (wq_occ_r != OCC_ZERO) && write_ready;
      pend_head_s = pend_mem_r[pend_rd_ptr_r];
      wq_head_s   = wq_mem_r[wq_rd_ptr_r];
   end

   assign pkt_ready     = pkt_ready_s;
   assign read_en       = pend_push_s;
   assign read_id       = pkt_flow_id;
   assign write_en      = wq_pop_s;
   assign stats_valid   = wq_pop_s;
   assign write_edit_id = wq_head_s[WQ_W-1 -: EDIT_ID_WIDTH];
   assign stats_flow_id = wq_head_s[DATA_WIDTH +: FLOW_ID_WIDTH];
   assign write_data    = wq_head_s[DATA_WIDTH-1:0];
   assign stats_count   = wq_head_s[DATA_WIDTH-1 -: COUNT_WIDTH];
   assign stats_bytes   = wq_head_s[BYTES_WIDTH-1:0];
   assign error         = error_r;

   // Pending FIFO storage and pointers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PENDING_DEPTH; i++) begin
            pend_mem_r[i] <= {PEND_W{1'b0}};
         end
         pend_wr_ptr_r <= {PTR_W{1'b0}};
         pend_rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
         if (pend_push_s) begin
            pend_mem_r[pend_wr_ptr_r] <= {pkt_flow_id, pkt_size};
            pend_wr_ptr_r             <= pend_wr_ptr_r + PTR_ONE;
         end
         if (pend_pop_s) begin
            pend_rd_ptr_r <= pend_rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Pending FIFO occupancy; simultaneous push and pop leave it unchanged
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_occ_r <= OCC_ZERO;
      end else begin
         case ({pend_push_s, pend_pop_s})
            2'b10:   pend_occ_r <= pend_occ_r + OCC_ONE;
            2'b01:   pend_occ_r <= pend_occ_r - OCC_ONE;
            default: pend_occ_r <= pend_occ_r;
         endcase
      end
   end

   // Compute register: updated record for the pending head
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_valid_r <= 1'b0;
         res_edit_r  <= {EDIT_ID_WIDTH{1'b0}};
         res_flow_r  <= {FLOW_ID_WIDTH{1'b0}};
         res_count_r <= {COUNT_WIDTH{1'b0}};
         res_bytes_r <= {BYTES_WIDTH{1'b0}};
      end else begin
         res_valid_r <= pend_pop_s;
         if (pend_pop_s) begin
            res_edit_r  <= read_edit_id;
            res_flow_r  <= pend_head_s[PEND_W-1 -: FLOW_ID_WIDTH];
            res_count_r <= next_count(read_data_found,
                                      read_data[DATA_WIDTH-1 -: COUNT_WIDTH]);
            res_bytes_r <= next_bytes(read_data_found,
                                      read_data[BYTES_WIDTH-1:0],
                                      pend_head_s[SIZE_WIDTH-1:0]);
         end
      end
   end

   // Write queue storage and pointers; fed from the compute register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PENDING_DEPTH; i++) begin
            wq_mem_r[i] <= {WQ_W{1'b0}};
         end
         wq_wr_ptr_r <= {PTR_W{1'b0}};
         wq_rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
         if (res_valid_r) begin
            wq_mem_r[wq_wr_ptr_r] <= {res_edit_r, res_flow_r, res_count_r, res_bytes_r};
            wq_wr_ptr_r           <= wq_wr_ptr_r + PTR_ONE;
         end
         if (wq_pop_s) begin
            wq_rd_ptr_r <= wq_rd_ptr_r + PTR_ONE;
         end
      end
   end

   // Write queue occupancy; simultaneous push and pop leave it unchanged
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wq_occ_r <= OCC_ZERO;
      end else begin
         case ({res_valid_r, wq_pop_s})
            2'b10:   wq_occ_r <= wq_occ_r + OCC_ONE;
            2'b01:   wq_occ_r <= wq_occ_r - OCC_ONE;
            default: wq_occ_r <= wq_occ_r;
         endcase
      end
   end

   // Sticky error: a read result with no outstanding read is discarded
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         error_r <= 1'b0;
      end else if (spurious_s) begin
         error_r <= 1'b1;
      end
   end

endmodule
